// File: rtl/pipe_pkg.sv
// Shared definitions for the 6-stage pipeline inter-stage registers.
// Holds the per-boundary bundle widths, the control-bundle bit positions,
// the field layout of the data bundle and a helper that packs it.
package pipe_pkg;

    localparam int PIPE_CTRL_W = 7;
    localparam int PIPE_DATA_W = 160;

    // Bundle widths per stage boundary (all boundaries share one layout today).
    localparam int IFID_CTRL_W  = PIPE_CTRL_W;
    localparam int IFID_DATA_W  = PIPE_DATA_W;
    localparam int IDRR_CTRL_W  = PIPE_CTRL_W;
    localparam int IDRR_DATA_W  = PIPE_DATA_W;
    localparam int RREX_CTRL_W  = PIPE_CTRL_W;
    localparam int RREX_DATA_W  = PIPE_DATA_W;
    localparam int EXMEM_CTRL_W = PIPE_CTRL_W;
    localparam int EXMEM_DATA_W = PIPE_DATA_W;
    localparam int MEMWB_CTRL_W = PIPE_CTRL_W;
    localparam int MEMWB_DATA_W = PIPE_DATA_W;

    // Control bundle bit positions.
    localparam int CTRL_REGWRITE = 0;
    localparam int CTRL_REGDST   = 1;
    localparam int CTRL_ALUOP    = 2;
    localparam int CTRL_MEMREAD  = 3;
    localparam int CTRL_MEMWRITE = 4;
    localparam int CTRL_MEMTOREG = 5;
    localparam int CTRL_BRANCH   = 6;

    // Data bundle field offsets (LSB of each field); bits 159:153 are spare.
    localparam int DATA_PC_OFS    = 0;
    localparam int DATA_DATA1_OFS = 32;
    localparam int DATA_DATA2_OFS = 64;
    localparam int DATA_EXT16_OFS = 96;
    localparam int DATA_RS_OFS    = 112;
    localparam int DATA_RT_OFS    = 117;
    localparam int DATA_RD_OFS    = 122;
    localparam int DATA_ADDR_OFS  = 127;

    function automatic logic [PIPE_DATA_W-1:0] pack_data(
        input logic [31:0] pc,
        input logic [31:0] data1,
        input logic [31:0] data2,
        input logic [15:0] ext16,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [4:0]  rd,
        input logic [25:0] address
    );
        return {7'b0, address, rd, rt, rs, ext16, data2, data1, pc};
    endfunction

endpackage

// File: rtl/pipe_skid_slot.sv
// One pipeline entry: valid flag plus control and data bundles.
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   flush            drop the entry; control cleared, data kept
//   load             capture in_ctrl/in_data and mark valid
//   clear            drop the entry (load wins if both are set)
//   in_ctrl, in_data entry to capture
//   valid, ctrl, data held entry
module pipe_skid_slot
    import pipe_pkg::*;
#(
    parameter int CTRL_W = PIPE_CTRL_W,
    parameter int DATA_W = PIPE_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              load,
    input  logic              clear,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data
);

    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            ctrl  <= '0;
            data  <= '0;
        end else if (flush) begin
            valid <= 1'b0;
            ctrl  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            ctrl  <= in_ctrl;
            data  <= in_data;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage register for the 6-stage pipeline (IF/ID .. MEM/WB).
// Moves a control and a data bundle across a valid/ready handshake,
// optionally through a 2-entry skid buffer, with flush-to-bubble and a
// saturating bubble counter.
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   flush                kill held entries and the entry offered this cycle
//   in_valid, in_ready   upstream handshake
//   in_ctrl, in_data     upstream bundles
//   out_valid, out_ready downstream handshake
//   out_ctrl, out_data   downstream bundles (out_ctrl is zero on bubbles)
//   bubble_cnt           cycles with out_valid=0 and out_ready=1, saturating
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W = PIPE_CTRL_W,
    parameter int DATA_W = PIPE_DATA_W,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic              main_valid;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;
    logic              main_load;
    logic              main_clear;
    logic [CTRL_W-1:0] main_in_ctrl;
    logic [DATA_W-1:0] main_in_data;
    logic              accept;
    logic              consume;

    assign accept  = in_valid & in_ready;
    assign consume = main_valid & out_ready;

    generate
        if (SKID != 0) begin : g_skid
            logic              skid_valid;
            logic [CTRL_W-1:0] skid_ctrl;
            logic [DATA_W-1:0] skid_data;
            logic              skid_load;
            logic              skid_clear;

            // Ready depends only on the skid flop, so no combinational path
            // from out_ready back to in_ready.
            assign in_ready = ~skid_valid;

            // With skid full in_ready is low, so an accept never coincides
            // with a skid-to-main move and the mux can key on skid_valid.
            assign main_load    = (consume & skid_valid) |
                                  (accept & (~main_valid | consume));
            assign main_clear   = consume;
            assign main_in_ctrl = skid_valid ? skid_ctrl : in_ctrl;
            assign main_in_data = skid_valid ? skid_data : in_data;

            assign skid_load  = accept & main_valid & ~consume;
            assign skid_clear = consume & skid_valid;

            pipe_skid_slot #(
                .CTRL_W (CTRL_W),
                .DATA_W (DATA_W)
            ) u_skid_slot (
                .clk     (clk),
                .reset   (reset),
                .flush   (flush),
                .load    (skid_load),
                .clear   (skid_clear),
                .in_ctrl (in_ctrl),
                .in_data (in_data),
                .valid   (skid_valid),
                .ctrl    (skid_ctrl),
                .data    (skid_data)
            );
        end else begin : g_pass
            assign in_ready     = ~main_valid | out_ready;
            assign main_load    = accept;
            assign main_clear   = consume;
            assign main_in_ctrl = in_ctrl;
            assign main_in_data = in_data;
        end
    endgenerate

    pipe_skid_slot #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W)
    ) u_main_slot (
        .clk     (clk),
        .reset   (reset),
        .flush   (flush),
        .load    (main_load),
        .clear   (main_clear),
        .in_ctrl (main_in_ctrl),
        .in_data (main_in_data),
        .valid   (main_valid),
        .ctrl    (main_ctrl),
        .data    (main_data)
    );

    assign out_valid = main_valid;
    assign out_ctrl  = main_valid ? main_ctrl : '0;
    assign out_data  = main_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            bubble_cnt <= '0;
        end else if (~main_valid & out_ready & ~(&bubble_cnt)) begin
            bubble_cnt <= bubble_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    localparam int CW = 7;
    localparam int DW = 160;
    typedef logic [CW+DW-1:0] ent_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          flush = 1'b0;

    // SKID=1, CNT_W=4 instance
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [CW-1:0] in_ctrl = '0;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
    logic [3:0]    bubble_cnt;

    // SKID=0, CNT_W=16 instance
    logic          in_valid_p = 1'b0;
    logic          in_ready_p;
    logic [CW-1:0] in_ctrl_p = '0;
    logic [DW-1:0] in_data_p = '0;
    logic          out_valid_p;
    logic          out_ready_p = 1'b0;
    logic [CW-1:0] out_ctrl_p;
    logic [DW-1:0] out_data_p;
    logic [15:0]   bubble_cnt_p;

    int    errors = 0;
    int    checks = 0;
    bit    mon_on = 1'b0;
    ent_t  sb[$];
    ent_t  sb_p[$];
    logic [3:0]  bc_m = '0;
    logic [15:0] bcp_m = '0;
    int    p_done = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .CNT_W(4)) dut_skid (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
        .bubble_cnt(bubble_cnt)
    );

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(0), .CNT_W(16)) dut_pass (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid_p), .in_ready(in_ready_p), .in_ctrl(in_ctrl_p), .in_data(in_data_p),
        .out_valid(out_valid_p), .out_ready(out_ready_p), .out_ctrl(out_ctrl_p), .out_data(out_data_p),
        .bubble_cnt(bubble_cnt_p)
    );

    function automatic ent_t mk(input int n);
        logic [CW-1:0] c;
        c = CW'(n * 37 + 1);
        return {c, pack_data(32'(n) * 4 + 32'h400, ~32'(n), 32'(n) * 3, 16'(n),
                             5'(n), 5'(n + 1), 5'(n + 2), 26'(n))};
    endfunction

    // Reference model + scoreboard for the SKID=1 instance.
    always @(negedge clk) begin
        bit ready_m;
        ready_m = (sb.size() < 2);
        if (mon_on) begin
            checks++;
            if (in_ready !== ready_m) begin
                errors++;
                $display("FAIL skid_in_ready: got %b expected %b", in_ready, ready_m);
            end
            checks++;
            if (out_valid !== (sb.size() > 0)) begin
                errors++;
                $display("FAIL skid_out_valid: got %b expected %b", out_valid, sb.size() > 0);
            end
            checks++;
            if (sb.size() > 0) begin
                if ({out_ctrl, out_data} !== sb[0]) begin
                    errors++;
                    $display("FAIL skid_entry: got %h expected %h", {out_ctrl, out_data}, sb[0]);
                end
            end else if (out_ctrl !== '0) begin
                errors++;
                $display("FAIL skid_ctrl_mask: got %h expected 0", out_ctrl);
            end
            checks++;
            if (bubble_cnt !== bc_m) begin
                errors++;
                $display("FAIL skid_bubble_cnt: got %0d expected %0d", bubble_cnt, bc_m);
            end
        end
        if (reset) begin
            sb.delete();
            bc_m = '0;
        end else begin
            if (sb.size() == 0 && out_ready && bc_m != 4'hF) bc_m = bc_m + 4'd1;
            if (flush) begin
                sb.delete();
            end else begin
                if (sb.size() > 0 && out_ready) void'(sb.pop_front());
                if (in_valid && ready_m) sb.push_back({in_ctrl, in_data});
            end
        end
    end

    // Reference model + scoreboard for the SKID=0 instance.
    always @(negedge clk) begin
        bit ready_m;
        ready_m = (sb_p.size() == 0) || out_ready_p;
        if (mon_on) begin
            checks++;
            if (in_ready_p !== ready_m) begin
                errors++;
                $display("FAIL pass_in_ready: got %b expected %b", in_ready_p, ready_m);
            end
            checks++;
            if (out_valid_p !== (sb_p.size() > 0)) begin
                errors++;
                $display("FAIL pass_out_valid: got %b expected %b", out_valid_p, sb_p.size() > 0);
            end
            checks++;
            if (sb_p.size() > 0) begin
                if ({out_ctrl_p, out_data_p} !== sb_p[0]) begin
                    errors++;
                    $display("FAIL pass_entry: got %h expected %h", {out_ctrl_p, out_data_p}, sb_p[0]);
                end
            end else if (out_ctrl_p !== '0) begin
                errors++;
                $display("FAIL pass_ctrl_mask: got %h expected 0", out_ctrl_p);
            end
            checks++;
            if (bubble_cnt_p !== bcp_m) begin
                errors++;
                $display("FAIL pass_bubble_cnt: got %0d expected %0d", bubble_cnt_p, bcp_m);
            end
        end
        if (reset) begin
            sb_p.delete();
            bcp_m = '0;
        end else begin
            if (sb_p.size() == 0 && out_ready_p && bcp_m != 16'hFFFF) bcp_m = bcp_m + 16'd1;
            if (flush) begin
                sb_p.delete();
            end else begin
                if (sb_p.size() > 0 && out_ready_p) begin
                    void'(sb_p.pop_front());
                    p_done++;
                end
                if (in_valid_p && ready_m) sb_p.push_back({in_ctrl_p, in_data_p});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        mon_on = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_ctrl !== '0) begin errors++; $display("FAIL rst_out_ctrl: got %h expected 0", out_ctrl); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL rst_out_data: got %h expected 0", out_data); end
        checks++; if (bubble_cnt !== 4'd0) begin errors++; $display("FAIL rst_bubble: got %0d expected 0", bubble_cnt); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b expected 1", in_ready); end
        checks++; if (in_ready_p !== 1'b1) begin errors++; $display("FAIL rst_in_ready_p: got %b expected 1", in_ready_p); end
        reset = 1'b0;
        in_valid = 1'b1;
        in_ctrl = 7'h41;
        in_data = {20{8'hA5}};
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL first_out_valid: got %b expected 1", out_valid); end
        checks++; if (out_ctrl !== 7'h41) begin errors++; $display("FAIL first_out_ctrl: got %h expected 41", out_ctrl); end
        checks++; if (out_data !== {20{8'hA5}}) begin errors++; $display("FAIL first_out_data: got %h expected a5..", out_data); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL first_in_ready: got %b expected 1", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL first_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_stall_skid();
        in_valid = 1'b1;
        {in_ctrl, in_data} = mk(1);
        out_ready = 1'b1;
        tick();
        {in_ctrl, in_data} = mk(2);
        out_ready = 1'b0;
        tick();
        {in_ctrl, in_data} = mk(3);
        tick();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready: got %b expected 0", in_ready); end
        checks++; if ({out_ctrl, out_data} !== mk(1)) begin errors++; $display("FAIL stall_hold: got %h expected %h", {out_ctrl, out_data}, mk(1)); end
        tick();
        checks++; if ({out_ctrl, out_data} !== mk(1)) begin errors++; $display("FAIL stall_hold2: got %h expected %h", {out_ctrl, out_data}, mk(1)); end
        out_ready = 1'b1;
        tick();
        checks++; if ({out_ctrl, out_data} !== mk(2)) begin errors++; $display("FAIL release_e2: got %h expected %h", {out_ctrl, out_data}, mk(2)); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b expected 1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if ({out_ctrl, out_data} !== mk(3)) begin errors++; $display("FAIL release_e3: got %h expected %h", {out_ctrl, out_data}, mk(3)); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL release_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid = 1'b1;
        {in_ctrl, in_data} = mk(5);
        tick();
        {in_ctrl, in_data} = mk(6);
        tick();
        {in_ctrl, in_data} = mk(7);
        flush = 1'b1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_full_ready: got %b expected 0", in_ready); end
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_ctrl !== '0) begin errors++; $display("FAIL flush_out_ctrl: got %h expected 0", out_ctrl); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready: got %b expected 1", in_ready); end
        in_valid = 1'b1;
        {in_ctrl, in_data} = mk(8);
        tick();
        {in_ctrl, in_data} = mk(9);
        flush = 1'b1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_offer_ready: got %b expected 1", in_ready); end
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_drop: got %b expected 0", out_valid); end
        tick();
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_ghost: got %b expected 0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_pass_through();
        int   sent;
        int   base;
        logic acc;
        in_valid_p = 1'b1;
        {in_ctrl_p, in_data_p} = mk(100);
        out_ready_p = 1'b1;
        tick();
        {in_ctrl_p, in_data_p} = mk(101);
        out_ready_p = 1'b0;
        #1;
        checks++; if (in_ready_p !== 1'b0) begin errors++; $display("FAIL pass_ready_low: got %b expected 0", in_ready_p); end
        out_ready_p = 1'b1;
        #1;
        checks++; if (in_ready_p !== 1'b1) begin errors++; $display("FAIL pass_ready_comb: got %b expected 1", in_ready_p); end
        tick();
        in_valid_p = 1'b0;
        tick();
        sent = 0;
        base = p_done;
        for (int cyc = 0; cyc < 400 && (p_done - base) < 20; cyc++) begin
            if (sent < 20) begin
                in_valid_p = 1'($urandom_range(0, 1));
                {in_ctrl_p, in_data_p} = mk(200 + sent);
            end else begin
                in_valid_p = 1'b0;
            end
            out_ready_p = 1'($urandom_range(0, 1));
            @(negedge clk);
            acc = in_valid_p & in_ready_p;
            tick();
            if (acc) sent++;
        end
        in_valid_p = 1'b0;
        out_ready_p = 1'b0;
        checks++; if ((p_done - base) !== 20) begin errors++; $display("FAIL pass_transfers: got %0d expected 20", p_done - base); end
        checks++; if (sb_p.size() !== 0) begin errors++; $display("FAIL pass_leftover: got %0d expected 0", sb_p.size()); end
    endtask

    task automatic test_bubble();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        checks++; if (bubble_cnt !== 4'd0) begin errors++; $display("FAIL bubble_start: got %0d expected 0", bubble_cnt); end
        repeat (5) tick();
        checks++; if (bubble_cnt !== 4'd5) begin errors++; $display("FAIL bubble_5: got %0d expected 5", bubble_cnt); end
        repeat (15) tick();
        checks++; if (bubble_cnt !== 4'd15) begin errors++; $display("FAIL bubble_sat: got %0d expected 15", bubble_cnt); end
        repeat (3) tick();
        checks++; if (bubble_cnt !== 4'd15) begin errors++; $display("FAIL bubble_hold: got %0d expected 15", bubble_cnt); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if (bubble_cnt !== 4'd15) begin errors++; $display("FAIL bubble_flush: got %0d expected 15", bubble_cnt); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (bubble_cnt !== 4'd0) begin errors++; $display("FAIL bubble_reset: got %0d expected 0", bubble_cnt); end
        out_ready = 1'b0;
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b0;
        in_valid = 1'b1;
        {in_ctrl, in_data} = mk(20);
        tick();
        {in_ctrl, in_data} = mk(21);
        tick();
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_full: got %b expected 0", in_ready); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_ctrl !== '0) begin errors++; $display("FAIL mid_out_ctrl: got %h expected 0", out_ctrl); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL mid_out_data: got %h expected 0", out_data); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready: got %b expected 1", in_ready); end
    endtask

    initial begin
        test_reset();
        test_stall_skid();
        test_flush();
        test_pass_through();
        test_bubble();
        test_mid_reset();
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
